// File: rtl/crc32_pkg.sv
// crc32_pkg
//   Shared constants and the single-bit LFSR step for the MSB-first
//   Ethernet-polynomial CRC-32 (BZIP2 flavour: init all-ones, no bit
//   reflection, final complement).
//
//   CRC32_POLY     generator polynomial, x^32 term implicit
//   CRC32_INIT     register value after reset
//   CRC32_RESIDUE  complemented register value after a frame followed by
//                  its own FCS (MSB first) has been fed through the engine
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'h38FB2284;

    // One bit through the LFSR with an explicit polynomial, so that
    // parameterised instances can use a non-default generator.
    function automatic logic [31:0] crc32_bit_step_p(
        input logic [31:0] r,
        input logic        b,
        input logic [31:0] poly
    );
        logic fb;
        fb = b ^ r[31];
        return {r[30:0], 1'b0} ^ (fb ? poly : 32'h0000_0000);
    endfunction

    // One bit through the LFSR using the Ethernet polynomial.
    function automatic logic [31:0] crc32_bit_step(
        input logic [31:0] r,
        input logic        b
    );
        return crc32_bit_step_p(r, b, CRC32_POLY);
    endfunction

endpackage

// File: rtl/crc32_dibit_step.sv
// crc32_dibit_step
//   Purely combinational next-state logic: advances a CRC-32 register by
//   one dibit. dibit_i[1] is the earlier bit on the wire and is applied
//   first, dibit_i[0] second.
//
//   Ports:
//     state_i  [31:0]  current CRC register
//     dibit_i  [1:0]   input symbol, MSB earlier
//     state_o  [31:0]  register after both bits
module crc32_dibit_step
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY
) (
    input  logic [31:0] state_i,
    input  logic [1:0]  dibit_i,
    output logic [31:0] state_o
);

    logic [31:0] mid;

    always_comb begin
        mid     = crc32_bit_step_p(state_i, dibit_i[1], POLY);
        state_o = crc32_bit_step_p(mid,     dibit_i[0], POLY);
    end

endmodule

// File: rtl/crc32_dibit.sv
// crc32_dibit
//   Streaming CRC-32 engine, one 2-bit symbol per clock, no back-pressure.
//   The register is never re-seeded on its own: a new frame needs a reset
//   pulse, otherwise further dibits continue the running checksum.
//
//   Ports:
//     clk          system clock, rising edge
//     rst          asynchronous reset, active low
//     axiiv        input dibit valid
//     axiid [1:0]  input dibit, [1] is the earlier bit
//     axiov        one-cycle pulse after the stream's valid drops
//     axiod [31:0] checksum (complement of the CRC register), held while idle
module crc32_dibit
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY,
    parameter logic [31:0] INIT = CRC32_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic        axiov,
    output logic [31:0] axiod
);

    logic [31:0] crc_d, crc_q;
    logic [31:0] crc_next;
    logic        was_vld_d, was_vld_q;
    logic        axiov_d, axiov_q;

    crc32_dibit_step #(
        .POLY (POLY)
    ) u_step (
        .state_i (crc_q),
        .dibit_i (axiid),
        .state_o (crc_next)
    );

    always_comb begin
        crc_d     = axiiv ? crc_next : crc_q;
        was_vld_d = axiiv;
        // Falling edge of valid: the register already holds the final
        // value, so flag it for the consumer.
        axiov_d   = was_vld_q & ~axiiv;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_q     <= INIT;
            was_vld_q <= 1'b0;
            axiov_q   <= 1'b0;
        end else begin
            crc_q     <= crc_d;
            was_vld_q <= was_vld_d;
            axiov_q   <= axiov_d;
        end
    end

    assign axiod = ~crc_q;
    assign axiov = axiov_q;

endmodule

// File: tb/tb_crc32_dibit.sv
// tb_crc32_dibit
//   Directed-vector bench for crc32_dibit. Inputs are driven and outputs
//   sampled 1 time unit after each rising edge.
module tb_crc32_dibit;

    logic        clk;
    logic        rst;
    logic        axiiv;
    logic [1:0]  axiid;
    logic        axiov;
    logic [31:0] axiod;

    int n_vec;
    int n_err;

    localparam logic [31:0] CHECK_123 = 32'hFC891918;
    localparam logic [31:0] RESIDUE   = 32'h38FB2284;
    // ~f(f(FFFFFFFF,0),0): FFFFFFFF -> FB3EE249 -> F2BCD925, complemented.
    localparam logic [31:0] ONE_ZERO  = 32'h0D4326DA;

    byte msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    crc32_dibit dut (
        .clk   (clk),
        .rst   (rst),
        .axiiv (axiiv),
        .axiid (axiid),
        .axiov (axiov),
        .axiod (axiod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] d);
        axiiv = 1'b1;
        axiid = d;
        tick();
    endtask

    task automatic idle();
        axiiv = 1'b0;
        axiid = 2'b00;
        tick();
    endtask

    // Reset across one edge, released 1 unit after it.
    task automatic do_reset();
        axiiv = 1'b0;
        rst   = 1'b0;
        tick();
        chk("rst_axiod", axiod, 32'h0);
        chk("rst_axiov", {31'b0, axiov}, 32'h0);
        rst = 1'b1;
    endtask

    task automatic send_byte(input byte b);
        logic [7:0] v;
        v = b;
        send(v[7:6]);
        send(v[5:4]);
        send(v[3:2]);
        send(v[1:0]);
    endtask

    task automatic send_msg();
        for (int i = 0; i < 9; i++) send_byte(msg[i]);
    endtask

    initial begin
        logic [31:0] fcs;
        logic [31:0] held;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        axiiv = 1'b0;
        axiid = 2'b00;

        // ---- reset only, long idle ----
        #12;
        chk("in_rst_axiod", axiod, 32'h0);
        do_reset();
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 20; i++) begin
                idle();
                if (axiov) pulses++;
            end
            chk("idle_axiod", axiod, 32'h0);
            chk("idle_no_pulse", pulses, 0);
        end

        // ---- async reset kills a live pulse ----
        send(2'b01);
        idle();
        chk("pre_async_axiov", {31'b0, axiov}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("async_axiov", {31'b0, axiov}, 32'h0);
        chk("async_axiod", axiod, 32'h0);
        tick();
        rst = 1'b1;

        // ---- check string, contiguous ----
        do_reset();
        send_msg();
        chk("msg_axiod", axiod, CHECK_123);
        chk("msg_axiov_early", {31'b0, axiov}, 32'h0);
        idle();
        chk("msg_axiov_pulse", {31'b0, axiov}, 32'h1);
        chk("msg_axiod_at_pulse", axiod, CHECK_123);
        begin
            int pulses;
            int changes;
            pulses  = 0;
            changes = 0;
            for (int i = 0; i < 16; i++) begin
                idle();
                if (axiov) pulses++;
                if (axiod !== CHECK_123) changes++;
            end
            chk("msg_hold_pulses", pulses, 0);
            chk("msg_hold_changes", changes, 0);
        end

        // ---- check string with random gaps ----
        do_reset();
        begin
            int miss;
            int extra;
            miss  = 0;
            extra = 0;
            for (int i = 0; i < 9; i++) begin
                logic [7:0] v;
                v = msg[i];
                for (int k = 3; k >= 0; k--) begin
                    if ((i > 0 || k < 3) && $urandom_range(0, 2) == 0) begin
                        int g;
                        g = $urandom_range(1, 3);
                        for (int j = 0; j < g; j++) begin
                            idle();
                            if (j == 0 && !axiov) miss++;
                            if (j != 0 && axiov) extra++;
                        end
                    end
                    send(v[2*k +: 2]);
                end
            end
            chk("gap_missed_pulses", miss, 0);
            chk("gap_extra_pulses", extra, 0);
        end
        chk("gap_axiod", axiod, CHECK_123);
        idle();
        chk("gap_final_pulse", {31'b0, axiov}, 32'h1);

        // ---- frame + FCS gives residue ----
        do_reset();
        send_msg();
        fcs = CHECK_123;
        for (int k = 15; k >= 0; k--) send(fcs[2*k +: 2]);
        chk("residue", axiod, RESIDUE);
        idle();

        // ---- reset mid-stream, then clean frame ----
        do_reset();
        send_byte(msg[0]);
        send_byte(msg[1]);
        send(2'b00);
        send(2'b11);
        held = axiod;
        do_reset();
        chk("mid_rst_cleared", axiod, 32'h0);
        send_msg();
        chk("mid_rst_axiod", axiod, CHECK_123);
        idle();
        chk("mid_rst_pulse", {31'b0, axiov}, 32'h1);

        // ---- single zero dibit, valid raised with reset release ----
        axiiv = 1'b0;
        rst   = 1'b0;
        tick();
        rst   = 1'b1;
        axiiv = 1'b1;
        axiid = 2'b00;
        tick();
        chk("one_dibit_axiod", axiod, ONE_ZERO);
        chk("one_dibit_no_pulse_yet", {31'b0, axiov}, 32'h0);
        idle();
        chk("one_dibit_pulse", {31'b0, axiov}, 32'h1);
        idle();
        chk("one_dibit_pulse_ends", {31'b0, axiov}, 32'h0);
        chk("one_dibit_hold", axiod, ONE_ZERO);

        // ---- no re-init: a second stream continues the running CRC ----
        send(2'b00);
        chk("continue_differs", {31'b0, (axiod == ONE_ZERO)}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
